// File: rtl/mult_seq_ctrl_if.sv
// Request/operand and product/status bundle for the shift-add multiplier controller.
// master = operand sources and product consumers, slave = the controller.
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic                 req0;
  logic [WIDTH-1:0]     x0;
  logic [WIDTH-1:0]     y0;
  logic                 req1;
  logic [WIDTH-1:0]     x1;
  logic [WIDTH-1:0]     y1;
  logic [1:0]           gnt;
  logic                 busy;
  logic                 done;
  logic                 done_id;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output req0, x0, y0, req1, x1, y1,
    input  gnt, busy, done, done_id, p
  );

  modport slave (
    input  req0, x0, y0, req1, x1, y1,
    output gnt, busy, done, done_id, p
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Round-robin shared shift-add multiplier; product and done pulse 2*WIDTH+1 cycles after the grant.
// No backpressure: requests are only seen in IDLE, a grant always runs to completion.
module mult_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           gnt_q, gnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 done_id_q, done_id_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 win;
  logic [2*WIDTH:0]     shift_aq;

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    p_d       = p_q;
    a_d       = a_q;
    q_d       = q_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    win       = 1'b0;
    shift_aq  = {a_q, q_q} >> 1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          // On a tie the requester that was not served last goes next.
          win     = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
          gnt_d   = win ? 2'b10 : 2'b01;
          last_d  = win;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        b_d     = last_q ? bus.x1 : bus.x0;
        q_d     = last_q ? bus.y1 : bus.y0;
        a_d     = '0;
        cnt_d   = '0;
        state_d = S_ADD;
      end
      S_ADD: begin
        if (q_q[0]) begin
          a_d = a_q + {1'b0, b_q};
        end
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {a_d, q_d} = shift_aq;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Product is captured on entry to DONE so it is valid alongside the pulse.
          p_d       = shift_aq[2*WIDTH-1:0];
          done_d    = 1'b1;
          done_id_d = last_q;
          state_d   = S_DONE;
        end else begin
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      p_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      p_q       <= p_d;
      a_q       <= a_d;
      q_q       <= q_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.p       = p_q;
endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Sequencing controller for the shift-add multiplier datapath: accumulator A (WIDTH+1 bits), multiplier register Q, multiplicand register B.
- Arbitrates round-robin between two requesters for the single datapath.
- Loads the winner's operands, runs WIDTH add/shift iterations, and returns a registered 2*WIDTH-bit product with a one-cycle done pulse.
- Sits between operand sources and consumers of P; owns the datapath registers internally.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH; iteration count is WIDTH.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 request; holds until gnt[0] seen
x0  input  WIDTH  requester 0 multiplicand; stable while req0 high
y0  input  WIDTH  requester 0 multiplier; stable while req0 high
req1  input  1  requester 1 request
x1  input  WIDTH  requester 1 multiplicand
y1  input  WIDTH  requester 1 multiplier
gnt  output  2  one-hot grant, registered, high for exactly the LOAD cycle
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, product valid
done_id  output  1  requester index of current P; updates with done
p  output  2*WIDTH  product, registered, held until next done

Behaviour:
- Reset: state=IDLE, gnt=0, busy=0, done=0, done_id=0, p=0, A=0, Q=0, B=0, cnt=0, last=1 (req0 wins the first tie). Reset is asynchronous and aborts any operation at any state; no partial result reaches p.
- States: IDLE, LOAD, ADD, SHIFT, DONE.
- IDLE: if req0|req1 at the edge:
  - Pick winner: only requester asserting; if both, the one != last.
  - Next state LOAD; gnt <= onehot(winner); last <= winner.
  - Otherwise stay in IDLE, gnt=0.
- LOAD (gnt high this cycle): B <= x_winner, Q <= y_winner, A <= 0, cnt <= 0; gnt <= 0; next ADD.
- ADD: if Q[0], A <= A + {1'b0,B} (WIDTH+1-bit add, no overflow possible); else A holds. Next SHIFT.
- SHIFT:
  - {A,Q} <= {A,Q} >> 1, zero fill at MSB; cnt <= cnt+1.
  - If cnt == WIDTH-1 (pre-increment), next DONE; else next ADD.
- DONE: p <= {A[WIDTH-1:0], Q} (registered on entry, so valid while done=1); done=1 for this cycle only; done_id=winner; next IDLE.
- Latency: gnt high in cycle L; done high in cycle L+2*WIDTH+1 (L+9 for WIDTH=4). Minimum spacing between grants is 2*WIDTH+3 cycles.
- req dropped after grant: no effect; the operation completes.
- req raised or dropped while busy: ignored until IDLE.
- Requester holding req continuously after its grant is re-arbitrated at the next IDLE; round-robin guarantees alternation when both request.
- x/y sampled only at the end of LOAD; changes at any other time are don't-care.
- p and done_id keep their last values through subsequent operations until the next DONE.

Test Plan:
- Reset, req0=1, x0=3, y0=5 → gnt=01 in cycle L, done at L+9, p=8'd15, done_id=0, busy high L..L+9.
- req0 and req1 raised together after reset (x0=2,y0=7; x1=6,y1=4) → req0 served first (p=14, done_id=0), then gnt=10 with no other requester pending → p=24, done_id=1.
- req0 and req1 both held continuously for 4 operations → grants alternate 01,10,01,10; done pulses exactly one cycle each.
- Boundaries:
  - x0=15, y0=15 → p=8'd225 (0xE1).
  - x0=0, y0=9 → p=0.
  - x0=9, y0=0 → p=0 with A never updated.
- Assert rst_n=0 asynchronously mid-ADD of a 13*11 operation → immediately busy=0, p=0, done=0, state IDLE; after release, req1 with 13*11 → p=8'd143 at L+9.
- Change x0/y0 during ADD/SHIFT cycles → p reflects only the values present during LOAD.
